sequence_player: RTL

SEQUENCE_PLAYER -- requirements
Module: sequence_player

---
 rtl/sequence_player.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// Plays a latched sequence of direction elements as timed arrows: each element
// is shown for ON_TICKS display ticks, then blanked for OFF_TICKS ticks.
module sequence_player #(
    parameter int DIR_W     = 2,
    parameter int MAX_LEN   = 16,
    parameter int TICK_DIV  = 833333,
    parameter int ON_TICKS  = 30,
    parameter int OFF_TICKS = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MAX_LEN*DIR_W-1:0] sequence_data,
    input  logic [7:0]               length,
    input  logic                     start,
    input  logic                     abort,
    output logic [DIR_W-1:0]         direction_arrow,
    output logic                     arrow_valid,
    output logic [7:0]               index,
    output logic                     busy,
    output logic                     done
);

    localparam int CYC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] ON_LAST    = TICK_W'(ON_TICKS - 1);
    localparam logic [TICK_W-1:0] OFF_LAST   = TICK_W'(OFF_TICKS - 1);
    localparam logic [7:0]        MAX_LEN_8  = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [MAX_LEN*DIR_W-1:0] seq_q, seq_d;
    logic [7:0]               len_q, len_d;
    logic [7:0]               idx_q, idx_d;
    logic [CYC_W-1:0]         cyc_q, cyc_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [DIR_W-1:0]         arrow_q, arrow_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [7:0]               len_clamped;
    logic                     last_cyc;

    // Element 0 sits in the most significant DIR_W bits.
    function automatic logic [DIR_W-1:0] elem_of(input logic [MAX_LEN*DIR_W-1:0] seq,
                                                 input logic [7:0] i);
        elem_of = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (i == 8'(k)) elem_of = seq[(MAX_LEN-1-k)*DIR_W +: DIR_W];
        end
    endfunction

    assign len_clamped = (length > MAX_LEN_8) ? MAX_LEN_8 : length;
    assign last_cyc    = (cyc_q == CYC_LAST);

    // start is a level sampled only in IDLE (abort has priority there);
    // done is a single-cycle pulse after the last OFF interval, never after abort/reset.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cyc_d   = '0;
        tick_d  = '0;
        arrow_d = arrow_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    seq_d = sequence_data;
                    len_d = len_clamped;
                    idx_d = '0;
                    if (len_clamped != 8'd0) begin
                        state_d = S_ON;
                        arrow_d = elem_of(sequence_data, 8'd0);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_cyc && tick_q == ON_LAST) begin
                    state_d = S_OFF;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cyc_d   = last_cyc ? '0 : cyc_q + CYC_W'(1);
                    tick_d  = last_cyc ? tick_q + TICK_W'(1) : tick_q;
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_cyc && tick_q == OFF_LAST) begin
                    if (idx_q + 8'd1 < len_q) begin
                        state_d = S_ON;
                        idx_d   = idx_q + 8'd1;
                        arrow_d = elem_of(seq_q, idx_q + 8'd1);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    busy_d = 1'b1;
                    cyc_d  = last_cyc ? '0 : cyc_q + CYC_W'(1);
                    tick_d = last_cyc ? tick_q + TICK_W'(1) : tick_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
            tick_q  <= '0;
            arrow_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            tick_q  <= tick_d;
            arrow_q <= arrow_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign direction_arrow = arrow_q;
    assign arrow_valid     = valid_q;
    assign index           = idx_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
